mem_arbiter: RTL and testbench

//  Shares the single physical memory port of the mp3 LC-3b pipeline between
//  two requesters: instruction fetch (I, read-only) and the memory stage (D, read/write).

---
 rtl/mem_arbiter_pkg.sv | 6 +
 rtl/mem_arbiter.sv | 76 +++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: LC-3b memory word/mask types and the arbiter state encoding
package mem_arbiter_pkg;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0] lc3b_mem_wmask;
  typedef enum logic [1:0] {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D} lc3b_arb_state;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch (I) and mem stage (D), D-priority with I starvation guard
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_read,
  input  lc3b_word      if_address,
  output lc3b_word      if_rdata,
  output logic          if_resp,
  input  logic          d_read,
  input  logic          d_write,
  input  lc3b_mem_wmask d_byte_enable,
  input  lc3b_word      d_address,
  input  lc3b_word      d_wdata,
  output lc3b_word      d_rdata,
  output logic          d_resp,
  input  logic          mem_resp,
  input  lc3b_word      mem_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output lc3b_mem_wmask mem_byte_enable,
  output lc3b_word      mem_address,
  output lc3b_word      mem_wdata
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  lc3b_arb_state state_q, state_d;
  logic [3:0] starve_q, starve_d;
  lc3b_word addr_q, addr_d, wdata_q, wdata_d;
  lc3b_mem_wmask be_q, be_d;
  logic wr_q, wr_d;
  logic d_req, grant_i, grant_d, done;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      wr_q     <= wr_d;
      assert (!(d_read && d_write));
    end
  end
  always_comb begin
    d_req   = d_read | d_write;
    grant_i = state_q == ARB_IDLE && if_read && (!d_req || starve_q == LIMIT);
    grant_d = state_q == ARB_IDLE && d_req && !grant_i;
    done    = state_q != ARB_IDLE && mem_resp;
    state_d = grant_i ? ARB_SERVE_I : grant_d ? ARB_SERVE_D : done ? ARB_IDLE : state_q;
    starve_d = (grant_i || (grant_d && !if_read)) ? 4'd0
             : (grant_d && starve_q != LIMIT) ? starve_q + 4'd1 : starve_q;
    // a simultaneous read+write from D is resolved as a write
    addr_d  = grant_i ? if_address : grant_d ? d_address : addr_q;
    wdata_d = grant_i ? '0 : grant_d ? d_wdata : wdata_q;
    be_d    = grant_i ? 2'b11 : grant_d ? (d_write ? d_byte_enable : 2'b11) : be_q;
    wr_d    = grant_i ? 1'b0 : grant_d ? d_write : wr_q;
    mem_read        = state_q == ARB_SERVE_I || (state_q == ARB_SERVE_D && !wr_q);
    mem_write       = state_q == ARB_SERVE_D && wr_q;
    mem_byte_enable = state_q == ARB_IDLE ? 2'b00 : be_q;
    mem_address     = addr_q;
    mem_wdata       = wdata_q;
    if_resp  = done && state_q == ARB_SERVE_I;
    d_resp   = done && state_q == ARB_SERVE_D;
    if_rdata = mem_rdata;
    d_rdata  = mem_rdata;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters and memory with a transaction-level scoreboard
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  localparam int LIMIT = 4;
  logic clk = 0, reset = 1;
  logic if_read = 0, if_resp;
  lc3b_word if_address = 0, if_rdata;
  logic d_read = 0, d_write = 0, d_resp;
  lc3b_mem_wmask d_byte_enable = 0;
  lc3b_word d_address = 0, d_wdata = 0, d_rdata;
  logic mem_resp = 0, mem_read, mem_write;
  lc3b_word mem_rdata = 0, mem_address, mem_wdata;
  lc3b_mem_wmask mem_byte_enable;
  typedef struct {bit is_d; bit wr; lc3b_word addr; lc3b_word wdata; lc3b_mem_wmask be;} txn_t;
  txn_t exp_q[$];
  lc3b_word bmem[lc3b_word];
  lc3b_word rmem[lc3b_word];
  int checks = 0, errors = 0, starve_m = 0, fixed_lat = 0;
  bit free_m = 1, drive_en = 0, d_hammer = 0, force_resp = 0, i_seen = 0, d_seen = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_read(if_read), .if_address(if_address), .if_rdata(if_rdata), .if_resp(if_resp),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable), .d_address(d_address),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata)
  );
  function automatic lc3b_word merge(lc3b_word o, lc3b_word n, lc3b_mem_wmask be);
    return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask
  // reference arbiter: decides who owns each access from the request levels seen before the grant edge
  always @(negedge clk) begin : model
    txn_t t;
    if (reset) begin
      exp_q.delete();
      free_m = 1;
      starve_m = 0;
    end else begin
      if (free_m && (if_read || d_read || d_write)) begin
        t.is_d  = (d_read || d_write) && !(if_read && starve_m == LIMIT);
        t.wr    = t.is_d && d_write;
        t.addr  = t.is_d ? d_address : if_address;
        t.wdata = d_wdata;
        t.be    = t.wr ? d_byte_enable : 2'b11;
        starve_m = (t.is_d && if_read) ? ((starve_m < LIMIT) ? starve_m + 1 : LIMIT) : 0;
        exp_q.push_back(t);
        free_m = 0;
      end
      if (if_resp || d_resp) free_m = 1;
    end
  end
  always @(negedge clk) begin : monitor
    txn_t t;
    lc3b_word old;
    i_seen = if_resp;
    d_seen = d_resp;
    if (!reset) begin
      if (!(mem_read || mem_write)) chk("idle_no_resp", {30'd0, if_resp, d_resp}, 0);
      else if (exp_q.size() == 0) chk("unexpected_access", {30'd0, mem_read, mem_write}, 0);
      else begin
        t = exp_q[0];
        chk("mem_address", mem_address, t.addr);
        chk("mem_strobes", {30'd0, mem_read, mem_write}, t.wr ? 2'b01 : 2'b10);
        chk("mem_byte_enable", mem_byte_enable, t.be);
        if (t.wr) chk("mem_wdata", mem_wdata, t.wdata);
        if (if_resp || d_resp) begin
          chk("resp_owner", {30'd0, if_resp, d_resp}, t.is_d ? 2'b01 : 2'b10);
          old = rmem.exists(t.addr) ? rmem[t.addr] : t.addr ^ 16'h5a5a;
          if (t.wr) rmem[t.addr] = merge(old, t.wdata, t.be);
          else if (t.is_d) chk("d_rdata", d_rdata, old);
          else chk("if_rdata", if_rdata, old);
          exp_q.pop_front();
        end
      end
    end
  end
  initial begin : responder
    int cnt, lat;
    bit resp_c, resp_prev;
    lc3b_word old;
    cnt = 0; lat = 1; resp_prev = 0;
    forever begin
      @(posedge clk); #1;
      resp_c = 0;
      if (reset || resp_prev) cnt = 0;
      else if (mem_read || mem_write) begin
        if (cnt == 0) lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 3);
        cnt++;
        resp_c = cnt >= lat;
      end
      if (resp_c) begin
        old = bmem.exists(mem_address) ? bmem[mem_address] : mem_address ^ 16'h5a5a;
        mem_rdata = old;
        if (mem_write) bmem[mem_address] = merge(old, mem_wdata, mem_byte_enable);
      end else mem_rdata = drive_en ? 16'($urandom) : 16'h0;
      resp_prev = resp_c;
      mem_resp = resp_c | force_resp;
    end
  end
  initial forever begin : i_driver
    @(posedge clk); #1;
    if (reset || i_seen) if_read = 0;
    else if (drive_en && !if_read && $urandom_range(0, 1) == 1) if_read = 1;
    if (drive_en) if_address = 16'h3000 + 16'($urandom_range(0, 15));
  end
  initial forever begin : d_driver
    bit wr;
    @(posedge clk); #1;
    if (reset || d_seen) begin
      d_read = 0;
      d_write = 0;
    end
    if (d_hammer && d_seen && !reset) begin
      d_read = 1;
      d_address = d_address + 16'd2;
    end
    if (drive_en && !reset && !d_read && !d_write && $urandom_range(0, 3) != 0) begin
      wr = 1'($urandom_range(0, 1));
      d_read = !wr;
      d_write = wr;
    end
    if (drive_en) begin
      d_address = 16'h3000 + 16'($urandom_range(0, 15));
      d_wdata = 16'($urandom);
      d_byte_enable = 2'($urandom_range(1, 3));
    end
  end
  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic drain(string name);
    int k = 0;
    while ((exp_q.size() != 0 || if_read || d_read || d_write) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'd0, k < 200}, 1);
  endtask
  initial begin : main
    int n_rd, n_resp, owners[$];
    lc3b_word addrs[$];
    bit prev;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {27'd0, mem_read, mem_write, mem_byte_enable, if_resp, d_resp}, 0);
    chk("reset_bus", {mem_address, mem_wdata}, 0);
    chk("reset_rdata", {if_rdata, d_rdata}, 0);
    @(posedge clk); #1 reset = 0;
    bmem[16'h3000] = 16'h1234;
    rmem[16'h3000] = 16'h1234;
    fixed_lat = 2;
    @(posedge clk); #1;
    if_read = 1;
    if_address = 16'h3000;
    n_rd = 0; n_resp = 0;
    repeat (8) begin
      @(negedge clk);
      n_rd += int'(mem_read);
      if (if_resp) begin
        n_resp++;
        chk("lone_i_rdata", if_rdata, 16'h1234);
      end
    end
    chk("lone_i_read_cycles", n_rd, 2);
    chk("lone_i_resp_cycles", n_resp, 1);
    fixed_lat = 1;
    @(posedge clk); #1;
    if_read = 1; if_address = 16'h3002;
    d_read = 1; d_address = 16'h4000;
    prev = 0;
    repeat (12) begin
      @(negedge clk);
      if ((mem_read || mem_write) && !prev) addrs.push_back(mem_address);
      prev = mem_read || mem_write;
    end
    chk("both_count", addrs.size(), 2);
    if (addrs.size() == 2) begin
      chk("both_first_d", addrs[0], 16'h4000);
      chk("both_second_i", addrs[1], 16'h3002);
    end
    fixed_lat = 3;
    @(posedge clk); #1;
    d_write = 1; d_address = 16'h4001; d_byte_enable = 2'b10; d_wdata = 16'hAB00;
    @(posedge clk); #1;
    d_address = 16'hFFFF; d_byte_enable = 2'b01; d_wdata = 16'h0000;
    n_resp = 0;
    repeat (8) begin
      @(negedge clk);
      n_resp += int'(d_resp);
    end
    chk("d_write_resp_cycles", n_resp, 1);
    chk("d_write_stored", rmem.exists(16'h4001) ? rmem[16'h4001] : 16'h0, (16'h4001 ^ 16'h5a5a) & 16'h00ff | 16'hAB00);
    fixed_lat = 0;
    drain("drain_directed");
    @(posedge clk); #1;
    d_hammer = 1;
    if_read = 1; if_address = 16'h3004;
    d_read = 1; d_address = 16'h5000;
    for (int c = 0; c < 80 && owners.size() < 5; c++) begin
      @(negedge clk);
      if (d_resp) owners.push_back(1);
      if (if_resp) owners.push_back(0);
    end
    d_hammer = 0;
    chk("starve_seq_len", owners.size(), 5);
    for (int i = 0; i < owners.size(); i++) chk("starve_owner", owners[i], (i < LIMIT) ? 1 : 0);
    drain("drain_starve");
    drive_en = 1;
    repeat (3000) @(posedge clk);
    #1 drive_en = 0;
    drain("drain_random");
    @(negedge clk); #1 force_resp = 1;
    @(negedge clk); #1 force_resp = 0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_mem_resp", {28'd0, mem_read, mem_write, if_resp, d_resp}, 0);
    end
    fixed_lat = 10;
    @(posedge clk); #1;
    d_read = 1; d_address = 16'h5555;
    for (int c = 0; c < 5 && !mem_read; c++) @(negedge clk);
    chk("rst_mid_reached", {31'd0, mem_read}, 1);
    #1 reset = 1; d_read = 0;
    @(negedge clk);
    chk("rst_mid_strobes", {30'd0, mem_read, mem_write}, 0);
    chk("rst_mid_no_resp", {31'd0, d_resp}, 0);
    @(posedge clk); #1 reset = 0; fixed_lat = 0;
    n_resp = 0;
    repeat (10) begin
      @(negedge clk);
      n_resp += int'(d_resp) + int'(mem_read) + int'(mem_write);
    end
    chk("rst_mid_after", n_resp, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
